// File: rtl/seg7_to_bcd_reader.sv
// Recovers the BCD digit from a 7-segment bus after a debounce of STABLE_CYCLES samples.
// Optional SEG7_READER_ERRCNT_EN adds a saturating err_cnt output counting illegal patterns.
module seg7_to_bcd_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] Seg,
  output logic [3:0] BCD,
  output logic       blank,
  output logic       valid,
`ifdef SEG7_READER_ERRCNT_EN
  output logic       err,
  output logic [7:0] err_cnt
`else
  output logic       err
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(STABLE_CYCLES);

  state_t           state, state_nxt;
  logic [6:0]       seg_q, seg_q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit;
  logic [6:0]       sample;
  logic             unused_dp;

  logic             dec_legal;
  logic             dec_blank;
  logic [3:0]       dec_digit;

  assign sample    = Seg[6:0];
  assign unused_dp = Seg[7];

  // Pattern classification, gfedcba order; the lamp test pattern 7F reads as 8.
  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_digit = 4'd0;
    case (sample)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: dec_blank = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      seg_q <= 7'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      seg_q <= seg_q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce FSM: the first enabled sample always enters SETTLE, so a pattern that
  // happens to equal the cleared seg_q still needs the full count.
  always_comb begin
    state_nxt = state;
    seg_q_nxt = seg_q;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      seg_q_nxt = 7'd0;
      cnt_nxt   = '0;
    end else begin
      seg_q_nxt = sample;
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_ONE;
        end
        SETTLE: begin
          if (sample != seg_q) begin
            cnt_nxt = CNT_ONE;
          end else if (cnt == CNT_COMMIT) begin
            commit    = 1'b1;
            cnt_nxt   = CNT_FULL;
            state_nxt = LOCKED;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        LOCKED: begin
          if (sample != seg_q) begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_ONE;
          end else begin
            cnt_nxt = CNT_FULL;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      BCD   <= 4'd0;
      blank <= 1'b1;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= commit && dec_legal;
      err   <= commit && !dec_legal;
      if (commit && dec_legal) begin
        blank <= dec_blank;
        if (!dec_blank) begin
          BCD <= dec_digit;
        end
      end
    end
  end

`ifdef SEG7_READER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (commit && !dec_legal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_to_bcd_reader.sv
// Scoreboard bench for seg7_to_bcd_reader: each debounced pattern pushes its expected
// pulse (edge, kind, BCD, blank) and a negedge monitor pops and compares on every pulse.
module tb_seg7_to_bcd_reader;

  localparam int S = 4;
  localparam int W = 22;  // {edge[15:0], is_err, blank, bcd[3:0]}

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] Seg;
  logic [3:0] BCD;
  logic       blank;
  logic       valid;
  logic       err;
`ifdef SEG7_READER_ERRCNT_EN
  logic [7:0] err_cnt;
  int         exp_err_cnt;
`endif

  int tests;
  int failed;
  int edge_cnt;

  logic [W-1:0] exp_q[$];

  logic [3:0] exp_bcd;
  logic       exp_blank;
  logic [6:0] last_p;
  logic       fresh;
  int         run_len;
  int         run_start;

  seg7_to_bcd_reader #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .Seg     (Seg),
    .BCD     (BCD),
    .blank   (blank),
    .valid   (valid),
`ifdef SEG7_READER_ERRCNT_EN
    .err     (err),
    .err_cnt (err_cnt)
`else
    .err     (err)
`endif
  );

  // clock / edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  // -1 illegal, 10 blank, 0..9 digit
  function automatic int classify(input logic [6:0] p);
    logic [6:0] pats[10];
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (p == 7'h00) return 10;
    for (int i = 0; i < 10; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // Drive one enabled sample at a negedge; returns at the following negedge.
  task automatic drive_sample(input logic [6:0] p);
    int k;
    Seg = {1'($urandom_range(0, 1)), p};
    en  = 1'b1;
    if (fresh || p != last_p) begin
      run_len   = 1;
      run_start = edge_cnt + 1;
      fresh     = 1'b0;
    end else begin
      run_len++;
    end
    last_p = p;
    if (run_len == S) begin
      k = classify(p);
      if (k == 10) exp_blank = 1'b1;
      else if (k >= 0) begin
        exp_bcd   = 4'(k);
        exp_blank = 1'b0;
      end
`ifdef SEG7_READER_ERRCNT_EN
      if (k < 0 && exp_err_cnt < 255) exp_err_cnt++;
`endif
      exp_q.push_back({16'(run_start + S - 1), (k < 0), exp_blank, exp_bcd});
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) drive_sample(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en    = 1'b0;
      Seg   = 8'($urandom_range(0, 255));
      fresh = 1'b1;
      @(negedge clk);
      check("frozen_bcd", BCD, exp_bcd);
      check("frozen_blank", blank, exp_blank);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    exp_bcd   = 4'd0;
    exp_blank = 1'b1;
    fresh     = 1'b1;
    check("rst_bcd", BCD, 0);
    check("rst_blank", blank, 1);
    check("rst_valid", valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (valid && err) check("valid_err_excl", 1, 0);
    if (valid || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, err}, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_edge", edge_cnt, int'(e[21:6]));
        check("pulse_is_err", err, e[5]);
        check("pulse_blank", blank, e[4]);
        check("pulse_bcd", BCD, e[3:0]);
      end
    end
  end

  initial begin
    logic [6:0] rp;
    logic [6:0] legal_tbl[11];
    tests     = 0;
    failed    = 0;
    edge_cnt  = 0;
    rst       = 1'b1;
    en        = 1'b0;
    Seg       = 8'h00;
    exp_bcd   = 4'd0;
    exp_blank = 1'b1;
    fresh     = 1'b1;
    last_p    = 7'd0;
    run_len   = 0;
    run_start = 0;
`ifdef SEG7_READER_ERRCNT_EN
    exp_err_cnt = 0;
`endif
    legal_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h00};
    repeat (3) @(negedge clk);
    do_reset();

    // blank held from reset release
    hold(7'h00, 10);
    // digit walk including the lamp-test pattern
    hold(7'h06, 30);
    hold(7'h7F, 30);
    hold(7'h07, 30);
    hold(7'h5B, 30);
    hold(7'h6D, 30);
    check("walk_bcd", BCD, 5);
    // short glitch, then return to 5
    hold(7'h7D, 2);
    check("glitch_bcd", BCD, 5);
    hold(7'h6D, 10);
    // illegal pattern
    hold(7'h49, 10);
    check("illegal_bcd", BCD, 5);
    check("illegal_blank", blank, 0);
`ifdef SEG7_READER_ERRCNT_EN
    check("err_cnt_one", err_cnt, 1);
`endif
    // enable dropped mid-settle
    hold(7'h3F, 2);
    idle(5);
    hold(7'h3F, 10);
    check("en_resume_bcd", BCD, 0);
    // reset mid-settle
    hold(7'h4F, 2);
    do_reset();
    hold(7'h4F, 10);
    check("post_rst_bcd", BCD, 3);

    // random patterns and hold lengths, mostly legal
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) rp = 7'($urandom_range(0, 127));
      else rp = legal_tbl[$urandom_range(0, 10)];
      hold(rp, $urandom_range(1, 8));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    hold(last_p, S + 2);

    check("queue_empty", exp_q.size(), 0);
    check("final_bcd", BCD, exp_bcd);
    check("final_blank", blank, exp_blank);
`ifdef SEG7_READER_ERRCNT_EN
    check("final_err_cnt", err_cnt, exp_err_cnt);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_to_bcd_reader.md
Name: seg7_to_bcd_reader

Overview:
- Reads the 8-bit active-high segment bus produced by the team's BCD-to-7-segment decoder and recovers the displayed BCD digit.
- Segment inputs are asynchronous to clk. A pattern must be stable for a configurable number of samples before it is accepted.
- Each accepted pattern is classified as a digit 0-9, blank, or illegal. A loopback/self-check block sits beside the decoder, on the decoder's output side.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required to accept a pattern. Legal range 2..15.
- CNT_W, 4, width of the stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sampling enable. Low freezes the block.
- Seg  input  8  segment bus. Seg[0]=a .. Seg[6]=g, Seg[7]=dp. dp is ignored for classification.
- BCD  output  4  last accepted digit.
- blank  output  1  high when the last accepted pattern was all segments off.
- valid  output  1  one-cycle pulse on each accepted legal pattern (digit or blank).
- err  output  1  one-cycle pulse on each accepted illegal pattern.

Behaviour:
- Reset, sampled on a rising clk edge with rst=1:
  - BCD=0, blank=1, valid=0, err=0.
  - State=IDLE, cnt=0, sample register seg_q=0.
  - Reset takes priority over en and over any pending commit. A reset mid-SETTLE discards the partial pattern.
- Sampling, each edge with en=1: seg_q<=Seg[6:0].
  - If Seg[6:0]!=seg_q: cnt<=1, state<=SETTLE.
  - Otherwise cnt saturates at STABLE_CYCLES.
- States:
  - IDLE: after reset or while en=0. The first sample goes to SETTLE with cnt=1.
  - SETTLE: counting.
    - When a sample equals seg_q and cnt==STABLE_CYCLES-1: commit, cnt<=STABLE_CYCLES, state<=LOCKED.
    - A differing sample restarts with cnt=1.
  - LOCKED: no further commits while the pattern is unchanged. Any change goes to SETTLE with cnt=1.
- Latency: a pattern first sampled at edge k commits at edge k+STABLE_CYCLES-1. Outputs are registered and visible after that edge.
  - Example, STABLE_CYCLES=4: first sample at edge 10, commit at edge 13.
- Classification on commit, gfedcba in hex:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9. Each sets BCD to the digit, blank<=0, valid pulse.
  - 00 -> blank<=1, BCD unchanged, valid pulse.
  - Any other pattern -> err pulse. BCD and blank are unchanged, valid=0.
- Lamp test drives 7F on the decoder, which is indistinguishable from digit 8. It is reported as BCD=8 by design.
- valid and err are never high in the same cycle. Both are 0 on every non-commit cycle.
- en=0:
  - seg_q and cnt are cleared, state<=IDLE.
  - BCD and blank hold their values. valid=0, err=0.
  - A pattern in progress is discarded. After en rises the full STABLE_CYCLES count restarts.
- Glitch shorter than STABLE_CYCLES samples: no commit, and outputs keep their previous values.
  - Returning to the previously locked pattern re-commits after STABLE_CYCLES samples, with another valid pulse.

Optional Feature:
- Macro SEG7_READER_ERRCNT_EN.
- Defined: adds output port err_cnt [7:0].
  - Reset value 0.
  - Increments on every err pulse and saturates at 255.
  - Not cleared by en=0.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Reset release with Seg=00 held, STABLE_CYCLES=4 -> valid pulses once, 3 edges after the first sample; blank=1, BCD=0; no further pulses while Seg is held.
- Walk Seg 06,7F,07,5B,6D, each held 30 cycles -> BCD=1,8,7,2,5 in order, blank=0, exactly one valid per pattern, each at first sample +3 edges.
- Seg 6D held, then a 2-cycle glitch to 7D, then back to 6D -> no commit of 6; BCD stays 5; one re-commit valid after the return.
- Seg=49 (illegal) held 10 cycles -> single err pulse; BCD/blank unchanged; valid stays 0. With SEG7_READER_ERRCNT_EN defined -> err_cnt=1.
- en dropped for 5 cycles in mid-SETTLE, then Seg=3F with en=1 -> outputs frozen while en=0; commit of BCD=0 at 3 edges after the first enabled sample.
- rst asserted with Seg=4F held and 2 samples already counted -> next cycle BCD=0, blank=1, no pulse; after rst is released, BCD=3 commits 3 edges after the first sample.
